sc_regshifter_seq: RTL and testbench

Parametrised, multi-cycle universal shift register.
- Performs logical, arithmetic, rotate and serial-insert shifts by a programmable amount, one bit position per clock.
- Uses a start/busy/done handshake so a controller can issue an operation and wait for its completion.
- Keeps the synchronous clear/load priority scheme of the existing register blocks.
- Sits between the datapath bus and any serial consumer.

---
 rtl/sc_regshifter_pkg.sv | 21 ++
 rtl/sc_regshifter_step.sv | 56 +++++
 rtl/sc_regshifter_seq.sv | 123 ++++++++++++
 tb/tb_sc_regshifter_seq.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/sc_regshifter_pkg.sv
// Shared encodings for the sequential universal shift register.
package sc_regshifter_pkg;

    typedef enum logic [2:0] {
        MODE_HOLD = 3'b000,
        MODE_SLL  = 3'b001,
        MODE_SRL  = 3'b010,
        MODE_SRA  = 3'b011,
        MODE_ROL  = 3'b100,
        MODE_ROR  = 3'b101,
        MODE_SIL  = 3'b110,
        MODE_SIR  = 3'b111
    } mode_e;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_e;

endpackage

// File: rtl/sc_regshifter_step.sv
// Combinational single-position shifter: one step of the selected mode.
module sc_regshifter_step
    import sc_regshifter_pkg::*;
#(
    parameter int unsigned DATAWIDTH = 8
) (
    input  logic [DATAWIDTH-1:0] data_i,
    input  mode_e                mode_i,
    input  logic                 serial_i,
    output logic [DATAWIDTH-1:0] next_data_c_o,
    output logic                 out_bit_c_o
);

    localparam int unsigned DW = DATAWIDTH;

    // Left modes drop the MSB, right modes drop the LSB; rotates feed it back in.
    always_comb begin
        next_data_c_o = data_i;
        out_bit_c_o   = 1'b0;
        case (mode_i)
            MODE_SLL: begin
                next_data_c_o = {data_i[DW-2:0], 1'b0};
                out_bit_c_o   = data_i[DW-1];
            end
            MODE_SRL: begin
                next_data_c_o = {1'b0, data_i[DW-1:1]};
                out_bit_c_o   = data_i[0];
            end
            MODE_SRA: begin
                next_data_c_o = {data_i[DW-1], data_i[DW-1:1]};
                out_bit_c_o   = data_i[0];
            end
            MODE_ROL: begin
                next_data_c_o = {data_i[DW-2:0], data_i[DW-1]};
                out_bit_c_o   = data_i[DW-1];
            end
            MODE_ROR: begin
                next_data_c_o = {data_i[0], data_i[DW-1:1]};
                out_bit_c_o   = data_i[0];
            end
            MODE_SIL: begin
                next_data_c_o = {data_i[DW-2:0], serial_i};
                out_bit_c_o   = data_i[DW-1];
            end
            MODE_SIR: begin
                next_data_c_o = {serial_i, data_i[DW-1:1]};
                out_bit_c_o   = data_i[0];
            end
            default: begin
                next_data_c_o = data_i;
                out_bit_c_o   = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/sc_regshifter_seq.sv
// Multi-cycle universal shift register: one bit position per clock, start/busy/done handshake.
module sc_regshifter_seq
    import sc_regshifter_pkg::*;
#(
    parameter int unsigned RegSHIFTER_DATAWIDTH  = 8,
    parameter int unsigned RegSHIFTER_SHAMTWIDTH = 4
) (
    input  logic                             SC_RegSHIFTERSEQ_CLOCK_50,
    input  logic                             SC_RegSHIFTERSEQ_RESET_InLow,
    input  logic                             SC_RegSHIFTERSEQ_clear_InLow,
    input  logic                             SC_RegSHIFTERSEQ_load_InLow,
    input  logic                             SC_RegSHIFTERSEQ_start_InHigh,
    input  logic [2:0]                       SC_RegSHIFTERSEQ_mode_In,
    input  logic [RegSHIFTER_SHAMTWIDTH-1:0] SC_RegSHIFTERSEQ_shamt_In,
    input  logic                             SC_RegSHIFTERSEQ_serial_In,
    input  logic [RegSHIFTER_DATAWIDTH-1:0]  SC_RegSHIFTERSEQ_data_InBUS,
    output logic [RegSHIFTER_DATAWIDTH-1:0]  SC_RegSHIFTERSEQ_data_OutBUS,
    output logic                             SC_RegSHIFTERSEQ_serial_Out,
    output logic                             SC_RegSHIFTERSEQ_busy_Out,
    output logic                             SC_RegSHIFTERSEQ_done_Out
);

    localparam int unsigned DW = RegSHIFTER_DATAWIDTH;
    localparam int unsigned SW = RegSHIFTER_SHAMTWIDTH;

    state_e          state_q, state_d;
    mode_e           mode_q, mode_d;
    logic [DW-1:0]   data_q, data_d;
    logic [SW-1:0]   cnt_q, cnt_d;
    logic            serial_q, serial_d;
    logic            busy_q, done_q;

    logic [DW-1:0]   step_data;
    logic            step_bit;

    sc_regshifter_step #(
        .DATAWIDTH (DW)
    ) u_step (
        .data_i        (data_q),
        .mode_i        (mode_q),
        .serial_i      (SC_RegSHIFTERSEQ_serial_In),
        .next_data_c_o (step_data),
        .out_bit_c_o   (step_bit)
    );

    always_ff @(posedge SC_RegSHIFTERSEQ_CLOCK_50 or negedge SC_RegSHIFTERSEQ_RESET_InLow) begin
        if (!SC_RegSHIFTERSEQ_RESET_InLow) begin
            state_q  <= IDLE;
            mode_q   <= MODE_HOLD;
            data_q   <= '0;
            cnt_q    <= '0;
            serial_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            data_q   <= data_d;
            cnt_q    <= cnt_d;
            serial_q <= serial_d;
            busy_q   <= (state_d != IDLE);
            done_q   <= (state_d == DONE);
        end
    end

    // Clear has top priority everywhere; load and start are honoured only in IDLE.
    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        data_d   = data_q;
        cnt_d    = cnt_q;
        serial_d = serial_q;
        case (state_q)
            IDLE: begin
                if (!SC_RegSHIFTERSEQ_clear_InLow) begin
                    data_d = '0;
                end else if (!SC_RegSHIFTERSEQ_load_InLow) begin
                    data_d = SC_RegSHIFTERSEQ_data_InBUS;
                end else if (SC_RegSHIFTERSEQ_start_InHigh) begin
                    mode_d = mode_e'(SC_RegSHIFTERSEQ_mode_In);
                    if (SC_RegSHIFTERSEQ_shamt_In == '0) begin
                        state_d = DONE;
                    end else begin
                        cnt_d   = SC_RegSHIFTERSEQ_shamt_In;
                        state_d = SHIFT;
                    end
                end
            end
            SHIFT: begin
                if (!SC_RegSHIFTERSEQ_clear_InLow) begin
                    data_d  = '0;
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    data_d = step_data;
                    if (mode_q != MODE_HOLD) begin
                        serial_d = step_bit;
                    end
                    cnt_d = cnt_q - SW'(1);
                    if (cnt_q == SW'(1)) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (!SC_RegSHIFTERSEQ_clear_InLow) begin
                    data_d = '0;
                    cnt_d  = '0;
                end
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign SC_RegSHIFTERSEQ_data_OutBUS = data_q;
    assign SC_RegSHIFTERSEQ_serial_Out  = serial_q;
    assign SC_RegSHIFTERSEQ_busy_Out    = busy_q;
    assign SC_RegSHIFTERSEQ_done_Out    = done_q;

endmodule

// File: tb/tb_sc_regshifter_seq.sv
// Randomized bench for sc_regshifter_seq against an arithmetic reference of N-position shifts.
module tb_sc_regshifter_seq;

    localparam int unsigned DW = 8;
    localparam int unsigned SW = 4;

    logic          clk;
    logic          rst_n;
    logic          clear_n;
    logic          load_n;
    logic          start;
    logic [2:0]    mode;
    logic [SW-1:0] shamt;
    logic          ser_in;
    logic [DW-1:0] din;
    logic [DW-1:0] dout;
    logic          sout;
    logic          busy;
    logic          done;

    int n_checks;
    int n_fail;
    logic exp_so;

    sc_regshifter_seq #(
        .RegSHIFTER_DATAWIDTH  (DW),
        .RegSHIFTER_SHAMTWIDTH (SW)
    ) dut (
        .SC_RegSHIFTERSEQ_CLOCK_50     (clk),
        .SC_RegSHIFTERSEQ_RESET_InLow  (rst_n),
        .SC_RegSHIFTERSEQ_clear_InLow  (clear_n),
        .SC_RegSHIFTERSEQ_load_InLow   (load_n),
        .SC_RegSHIFTERSEQ_start_InHigh (start),
        .SC_RegSHIFTERSEQ_mode_In      (mode),
        .SC_RegSHIFTERSEQ_shamt_In     (shamt),
        .SC_RegSHIFTERSEQ_serial_In    (ser_in),
        .SC_RegSHIFTERSEQ_data_InBUS   (din),
        .SC_RegSHIFTERSEQ_data_OutBUS  (dout),
        .SC_RegSHIFTERSEQ_serial_Out   (sout),
        .SC_RegSHIFTERSEQ_busy_Out     (busy),
        .SC_RegSHIFTERSEQ_done_Out     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Result of applying amt single steps, built from whole-word shifts of a widened value.
    function automatic void model(input logic [DW-1:0] d, input logic [2:0] m, input int amt,
                                  input logic [15:0] sbits, output logic [DW-1:0] res,
                                  output logic so);
        logic [63:0] w;
        logic [63:0] fill;
        int r;
        w    = '0;
        fill = '0;
        res  = d;
        so   = 1'b0;
        case (m)
            3'b001, 3'b110: begin
                w = 64'(d) << amt;
                if (m == 3'b110) begin
                    for (int i = 0; i < amt; i++)
                        if (sbits[i]) w = w | (64'(1) << (amt - 1 - i));
                end
                res = w[DW-1:0];
                so  = w[DW];
            end
            3'b010, 3'b011, 3'b111: begin
                for (int i = 0; i < amt; i++) begin
                    if (m == 3'b011)      fill[i] = d[DW-1];
                    else if (m == 3'b111) fill[i] = sbits[i];
                end
                w   = 64'(d) | (fill << DW);
                res = DW'(w >> amt);
                so  = w[amt-1];
            end
            3'b100: begin
                r   = amt % DW;
                res = DW'((64'(d) << r) | (64'(d) >> (DW - r)));
                so  = res[0];
            end
            3'b101: begin
                r   = amt % DW;
                res = DW'((64'(d) >> r) | (64'(d) << (DW - r)));
                so  = res[DW-1];
            end
            default: begin
                res = d;
                so  = 1'b0;
            end
        endcase
    endfunction

    task automatic run_op(input logic [DW-1:0] d, input logic [2:0] m, input int n,
                          input logic [15:0] pat, input bit rnd_ser, input bit noise);
        logic [DW-1:0] er;
        logic          eso;
        logic [15:0]   bits;
        bits = '0;
        er   = d;
        load_n = 1'b0; din = d;
        tick();
        load_n = 1'b1;
        chk("load_data", 32'(dout), 32'(d));
        start = 1'b1; mode = m; shamt = SW'(n); ser_in = 1'($urandom);
        tick();
        start = 1'b0;
        chk("start_busy", 32'(busy), 32'(1));
        chk("start_done", 32'(done), 32'(n == 0));
        for (int i = 0; i < n; i++) begin
            ser_in  = rnd_ser ? 1'($urandom) : pat[i];
            bits[i] = ser_in;
            if (noise) begin
                load_n = 1'($urandom); din = DW'($urandom);
                start = 1'($urandom); mode = 3'($urandom); shamt = SW'($urandom);
            end
            tick();
            load_n = 1'b1; start = 1'b0;
            model(d, m, i + 1, bits, er, eso);
            if (m != 3'b000) exp_so = eso;
            chk("step_data", 32'(dout), 32'(er));
            chk("step_sout", 32'(sout), 32'(exp_so));
            chk("step_busy", 32'(busy), 32'(1));
            chk("step_done", 32'(done), 32'(i == n - 1));
        end
        if (noise) begin
            start = 1'b1; load_n = 1'b0; din = ~er; mode = 3'b001; shamt = SW'(3);
        end
        tick();
        start = 1'b0; load_n = 1'b1;
        chk("end_busy", 32'(busy), 32'(0));
        chk("end_done", 32'(done), 32'(0));
        chk("end_data", 32'(dout), 32'(er));
        chk("end_sout", 32'(sout), 32'(exp_so));
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        exp_so   = 1'b0;
        rst_n = 1'b0; clear_n = 1'b1; load_n = 1'b1; start = 1'b0;
        mode = '0; shamt = '0; ser_in = 1'b0; din = '0;
        #12;
        chk("rst_data", 32'(dout), 32'(0));
        chk("rst_sout", 32'(sout), 32'(0));
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_done", 32'(done), 32'(0));
        #10 rst_n = 1'b1;
        tick();

        run_op(8'hB4, 3'b001, 3, 16'h0, 1'b1, 1'b0);
        run_op(8'h90, 3'b011, 2, 16'h0, 1'b1, 1'b0);
        run_op(8'h81, 3'b101, 9, 16'h0, 1'b1, 1'b0);
        run_op(8'h81, 3'b010, 9, 16'h0, 1'b1, 1'b0);
        run_op(8'h00, 3'b110, 4, 16'b1101, 1'b0, 1'b0);
        chk("sil_result", 32'(dout), 32'(8'h0B));
        run_op(8'h0B, 3'b110, 0, 16'h0, 1'b1, 1'b0);
        run_op(8'h5A, 3'b000, 3, 16'h0, 1'b1, 1'b0);
        run_op(8'hA5, 3'b111, 15, 16'h0, 1'b1, 1'b0);
        run_op(8'h80, 3'b011, 12, 16'h0, 1'b1, 1'b0);

        // Abort: load ignored at shift 1, clear at shift 2.
        load_n = 1'b0; din = 8'hFF;
        tick();
        load_n = 1'b1;
        start = 1'b1; mode = 3'b001; shamt = SW'(5);
        tick();
        start = 1'b0; load_n = 1'b0; din = 8'h55;
        tick();
        load_n = 1'b1;
        chk("abort_s1_data", 32'(dout), 32'(8'hFE));
        chk("abort_s1_sout", 32'(sout), 32'(1));
        clear_n = 1'b0;
        tick();
        clear_n = 1'b1;
        chk("abort_data", 32'(dout), 32'(0));
        chk("abort_busy", 32'(busy), 32'(0));
        chk("abort_done", 32'(done), 32'(0));
        chk("abort_sout", 32'(sout), 32'(1));
        tick();
        chk("abort_done2", 32'(done), 32'(0));
        chk("abort_busy2", 32'(busy), 32'(0));
        exp_so = 1'b1;

        // Clear beats load and start in IDLE.
        load_n = 1'b0; din = 8'h3C;
        tick();
        clear_n = 1'b0; load_n = 1'b0; start = 1'b1; din = 8'hC3; mode = 3'b001; shamt = SW'(2);
        tick();
        clear_n = 1'b1; load_n = 1'b1; start = 1'b0;
        chk("clr_pri_data", 32'(dout), 32'(0));
        chk("clr_pri_busy", 32'(busy), 32'(0));
        tick();
        chk("clr_pri_done", 32'(done), 32'(0));

        // Asynchronous reset in the middle of a shift.
        load_n = 1'b0; din = 8'hF3;
        tick();
        load_n = 1'b1;
        start = 1'b1; mode = 3'b100; shamt = SW'(6);
        tick();
        start = 1'b0;
        tick();
        #2 rst_n = 1'b0;
        #1;
        chk("arst_data", 32'(dout), 32'(0));
        chk("arst_sout", 32'(sout), 32'(0));
        chk("arst_busy", 32'(busy), 32'(0));
        chk("arst_done", 32'(done), 32'(0));
        #2 rst_n = 1'b1;
        exp_so = 1'b0;
        tick();
        run_op(8'h81, 3'b100, 3, 16'h0, 1'b1, 1'b0);

        for (int k = 0; k < 40; k++) begin
            run_op(DW'($urandom), 3'($urandom), int'($urandom_range(0, 15)),
                   16'h0, 1'b1, 1'b1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
